// File: rtl/frq_msg_pkg.sv
// Shared types and constants for the serial message scheduler.
// FRQ_MSG_START_STOP_EN adds a start bit (0) and a stop bit (1) around the data bits.
package frq_msg_pkg;

    localparam int unsigned MSG_W   = 5;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned FIX_DIV = 8;

`ifdef FRQ_MSG_START_STOP_EN
    localparam int unsigned FRAME_W = MSG_W + 2;
`else
    localparam int unsigned FRAME_W = MSG_W;
`endif

    localparam int unsigned BIT_CNT_W = $clog2(FRAME_W);

    localparam logic MODE_LD  = 1'b0;
    localparam logic MODE_FIX = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bit pattern shifted out MSB first for one frame.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [MSG_W-1:0] m);
`ifdef FRQ_MSG_START_STOP_EN
        return {1'b0, m, 1'b1};
`else
        return m;
`endif
    endfunction

endpackage

// File: rtl/frq_tick_gen.sv
// Prescaler for the message scheduler: loadable-start or fixed-period tick.
// Tick is combinational so it marks the last cycle of the current bit period.
module frq_tick_gen
    import frq_msg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             mode,
    input  logic [CNT_W-1:0] sw_val,
    output logic             tick
);

    localparam logic [CNT_W-1:0] LD_TOP  = '1;
    localparam logic [CNT_W-1:0] FIX_TOP = CNT_W'(FIX_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] reload_c;
    logic [CNT_W-1:0] top_c;

    assign reload_c = (mode == MODE_LD)  ? sw_val : '0;
    assign top_c    = (mode == MODE_FIX) ? FIX_TOP : LD_TOP;
    assign tick     = en && (cnt_q == top_c);

    // Counter restarts from the reload value on load and after every tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load || tick) begin
            cnt_q <= reload_c;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/frq_msg_scheduler.sv
// Start/busy/done controlled serial transmitter of an MSG_W-bit message, MSB first.
// FRQ_MSG_START_STOP_EN wraps the data bits with a start bit and a stop bit.
module frq_msg_scheduler
    import frq_msg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sel,
    input  logic [CNT_W-1:0] SW,
    input  logic [MSG_W-1:0] msg,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_W - 1);

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   sreg_q, sreg_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 sel_q, sel_d;
    logic [CNT_W-1:0]     sw_q, sw_d;
    logic                 out_d, busy_d, done_d;
    logic                 tg_load_c, tg_en_c, tick_c;

    frq_tick_gen u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (tg_load_c),
        .en     (tg_en_c),
        .mode   (sel_q),
        .sw_val (sw_q),
        .tick   (tick_c)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        sel_d     = sel_q;
        sw_d      = sw_q;
        out_d     = out;
        busy_d    = busy;
        done_d    = 1'b0;
        tg_load_c = 1'b0;
        tg_en_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                out_d  = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    state_d   = LOAD;
                    busy_d    = 1'b1;
                    sreg_d    = build_frame(msg);
                    sel_d     = sel;
                    sw_d      = SW;
                    bit_cnt_d = '0;
                end
            end
            LOAD: begin
                tg_load_c = 1'b1;
                state_d   = SHIFT;
                busy_d    = 1'b1;
                out_d     = sreg_q[FRAME_W-1];
                sreg_d    = {sreg_q[FRAME_W-2:0], 1'b0};
            end
            SHIFT: begin
                tg_en_c = 1'b1;
                busy_d  = 1'b1;
                if (tick_c) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = DONE;
                        out_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        out_d     = sreg_q[FRAME_W-1];
                        sreg_d    = {sreg_q[FRAME_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                out_d   = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            sel_q     <= MODE_LD;
            sw_q      <= '0;
            out       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            sel_q     <= sel_d;
            sw_q      <= sw_d;
            out       <= out_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_frq_msg_scheduler.sv
// Bench for frq_msg_scheduler: directed scenarios then random traffic, every cycle
// compared against a timeline model (frame start cycle, period, bit index arithmetic).
module tb_frq_msg_scheduler;
    import frq_msg_pkg::*;

`ifdef FRQ_MSG_START_STOP_EN
    localparam int NB = MSG_W + 2;
`else
    localparam int NB = MSG_W;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sel;
    logic [CNT_W-1:0] SW;
    logic [MSG_W-1:0] msg;
    logic             out;
    logic             busy;
    logic             done;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Model state: cycle of the LOAD state (-1 = none), bit period, captured message.
    int               fs = -1;
    int               p  = 1;
    int               last_c;
    logic [MSG_W-1:0] m_msg = '0;
    logic             e_out, e_busy, e_done;
    logic             in_frame;

    frq_msg_scheduler dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sel   (sel),
        .SW    (SW),
        .msg   (msg),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic logic ref_bit(input int k, input logic [MSG_W-1:0] m);
`ifdef FRQ_MSG_START_STOP_EN
        if (k == 0) return 1'b0;
        if (k == MSG_W + 1) return 1'b1;
        return m[MSG_W-k];
`else
        return m[MSG_W-1-k];
`endif
    endfunction

    // Compare mid-cycle, then let the model see this cycle's inputs.
    always @(negedge clk) begin
        if (!rst) fs = -1;
        last_c   = fs + 1 + NB * p;
        in_frame = (fs >= 0) && (cyc >= fs) && (cyc <= last_c);
        e_out  = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (in_frame) begin
            if (cyc == fs) begin
                e_busy = 1'b1;
            end else if (cyc == last_c) begin
                e_done = 1'b1;
            end else begin
                e_busy = 1'b1;
                e_out  = ref_bit((cyc - fs - 1) / p, m_msg);
            end
        end
        check_val("out",  32'(out),  32'(e_out));
        check_val("busy", 32'(busy), 32'(e_busy));
        check_val("done", 32'(done), 32'(e_done));
        if (rst && start && !in_frame) begin
            fs    = cyc + 1;
            m_msg = msg;
            p     = sel ? int'(FIX_DIV) : (1 << CNT_W) - int'(SW);
        end
        cyc++;
    end

    task automatic apply(input logic r, input logic s, input logic sl,
                         input logic [CNT_W-1:0] w, input logic [MSG_W-1:0] m, input int n);
        @(posedge clk);
        #1;
        rst   = r;
        start = s;
        sel   = sl;
        SW    = w;
        msg   = m;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        SW    = '0;
        msg   = '0;
        #2 rst = 1'b0;

        // Reset with arbitrary inputs, then quiet idle
        apply(1'b0, 1'b1, 1'b1, 3'd4, 5'b11011, 3);
        apply(1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, 20);

        // Loadable mode, P=3
        apply(1'b1, 1'b1, 1'b0, 3'd5, 5'b10110, 1);
        apply(1'b1, 1'b0, 1'b0, 3'd5, 5'b10110, 28);

        // Fixed mode, SW ignored
        apply(1'b1, 1'b1, 1'b1, 3'd2, 5'b00001, 1);
        apply(1'b1, 1'b0, 1'b1, 3'd2, 5'b00001, 70);

        // Minimum period with start held high
        apply(1'b1, 1'b1, 1'b0, 3'd7, 5'b11111, 24);
        apply(1'b1, 1'b0, 1'b0, 3'd7, 5'b11111, 12);

        // Maximum loadable period
        apply(1'b1, 1'b1, 1'b0, 3'd0, 5'b01101, 1);
        apply(1'b1, 1'b0, 1'b0, 3'd0, 5'b01101, 72);

        // Inputs changed and start pulsed mid-frame
        apply(1'b1, 1'b1, 1'b0, 3'd5, 5'b10101, 1);
        apply(1'b1, 1'b0, 1'b0, 3'd5, 5'b10101, 4);
        apply(1'b1, 1'b1, 1'b1, 3'd6, 5'b01010, 1);
        apply(1'b1, 1'b0, 1'b1, 3'd6, 5'b01010, 30);

        // Reset during the third bit, then a fresh frame
        apply(1'b1, 1'b1, 1'b0, 3'd5, 5'b10110, 1);
        apply(1'b1, 1'b0, 1'b0, 3'd5, 5'b10110, 8);
        apply(1'b0, 1'b0, 1'b0, 3'd5, 5'b10110, 2);
        apply(1'b1, 1'b1, 1'b0, 3'd5, 5'b10110, 1);
        apply(1'b1, 1'b0, 1'b0, 3'd5, 5'b10110, 30);

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            apply(($urandom_range(149) != 0), ($urandom_range(5) == 0), 1'($urandom),
                  CNT_W'($urandom), MSG_W'($urandom), 1);
        end
        apply(1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, 80);

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
